// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and counter-width definitions for the ALU arbiter.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = (req0 && req1) ? ~last : req1;
        gnt = 2'b00;
        if (req0 || req1) begin
            gnt = win ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between two requesters: round-robin grant, hold inputs
// for WAIT_CYCLES, capture the result and pulse DONE to the granted requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [2:0] SEL0,
    input  logic [7:0] OPA0,
    input  logic [7:0] OPB0,
    output logic       GRANT0,
    output logic       DONE0,
    output logic [7:0] RESULT0,
    input  logic       REQ1,
    input  logic [2:0] SEL1,
    input  logic [7:0] OPA1,
    input  logic [7:0] OPB1,
    output logic       GRANT1,
    output logic       DONE1,
    output logic [7:0] RESULT1,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [7:0]       alu_d1_q, alu_d1_d;
    logic [7:0]       alu_d2_q, alu_d2_d;
    logic [7:0]       result0_q, result0_d;
    logic [7:0]       result1_q, result1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;

    logic [1:0] pick_gnt;
    logic       pick_win;
    logic       grant_ok;

    rr_pick2 u_pick (
        .req0 (REQ0),
        .req1 (REQ1),
        .last (last_q),
        .gnt  (pick_gnt),
        .win  (pick_win)
    );

    // A grant is only offered where the next edge will actually honour it.
    assign grant_ok = (state_q == ST_IDLE) && !RESET;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        alu_sel_d = alu_sel_q;
        alu_d1_d  = alu_d1_q;
        alu_d2_d  = alu_d2_q;
        result0_d = result0_q;
        result1_d = result1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok && (pick_gnt != 2'b00)) begin
                    state_d   = ST_EXEC;
                    cnt_d     = CNT_LOAD;
                    last_d    = pick_win;
                    owner_d   = pick_win;
                    alu_sel_d = pick_win ? SEL1 : SEL0;
                    alu_d1_d  = pick_win ? OPA1 : OPA0;
                    alu_d2_d  = pick_win ? OPB1 : OPB0;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RESP;
                    if (owner_q) begin
                        result1_d = ALU_RESULT;
                        done1_d   = 1'b1;
                    end else begin
                        result0_d = ALU_RESULT;
                        done0_d   = 1'b1;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            alu_sel_q <= OP_FWD;
            alu_d1_q  <= 8'h00;
            alu_d2_q  <= 8'h00;
            result0_q <= 8'h00;
            result1_q <= 8'h00;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            alu_sel_q <= alu_sel_d;
            alu_d1_q  <= alu_d1_d;
            alu_d2_q  <= alu_d2_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

    assign GRANT0     = grant_ok && pick_gnt[0];
    assign GRANT1     = grant_ok && pick_gnt[1];
    assign DONE0      = done0_q;
    assign DONE1      = done1_q;
    assign RESULT0    = result0_q;
    assign RESULT1    = result1_q;
    assign ALU_SELECT = alu_sel_q;
    assign ALU_DATA1  = alu_d1_q;
    assign ALU_DATA2  = alu_d2_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (WAIT_CYCLES 1 and 4), directed steps then
// random traffic, each cycle compared against a transaction-level reference model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req0, req1, grant0, grant1, done0, done1, busy;
    logic [1:0][2:0]  sel0, sel1, alu_sel;
    logic [1:0][7:0]  opa0, opb0, opa1, opb1, result0, result1, alu_d1, alu_d2, alu_res;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [7:0] alu_ref(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'b001:  return 8'(a + b);
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return b;
        endcase
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) alu_res[d] = alu_ref(alu_sel[d], alu_d1[d], alu_d2[d]);
    end

    alu_arbiter #(.WAIT_CYCLES(1)) u_w1 (
        .CLK(clk), .RESET(rst),
        .REQ0(req0[0]), .SEL0(sel0[0]), .OPA0(opa0[0]), .OPB0(opb0[0]),
        .GRANT0(grant0[0]), .DONE0(done0[0]), .RESULT0(result0[0]),
        .REQ1(req1[0]), .SEL1(sel1[0]), .OPA1(opa1[0]), .OPB1(opb1[0]),
        .GRANT1(grant1[0]), .DONE1(done1[0]), .RESULT1(result1[0]),
        .ALU_DATA1(alu_d1[0]), .ALU_DATA2(alu_d2[0]), .ALU_SELECT(alu_sel[0]),
        .ALU_RESULT(alu_res[0]), .BUSY(busy[0])
    );

    alu_arbiter #(.WAIT_CYCLES(4)) u_w4 (
        .CLK(clk), .RESET(rst),
        .REQ0(req0[1]), .SEL0(sel0[1]), .OPA0(opa0[1]), .OPB0(opb0[1]),
        .GRANT0(grant0[1]), .DONE0(done0[1]), .RESULT0(result0[1]),
        .REQ1(req1[1]), .SEL1(sel1[1]), .OPA1(opa1[1]), .OPB1(opb1[1]),
        .GRANT1(grant1[1]), .DONE1(done1[1]), .RESULT1(result1[1]),
        .ALU_DATA1(alu_d1[1]), .ALU_DATA2(alu_d2[1]), .ALU_SELECT(alu_sel[1]),
        .ALU_RESULT(alu_res[1]), .BUSY(busy[1])
    );

    // Reference model: cycles left until idle, who is in flight, last winner, results.
    int         waits[2] = '{1, 4};
    int         m_left[2];
    int         m_who[2];
    int         m_gw[2];
    bit         m_last[2];
    logic [7:0] m_res[2][2];
    logic [2:0] m_sel[2];
    logic [7:0] m_a[2];
    logic [7:0] m_b[2];
    bit         obs_g0[2];
    bit         obs_d1[2];
    bit         keep = 1'b0;
    bit         rnd = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d);
        bit q0, q1;
        string p;
        p  = $sformatf("w%0d ", waits[d]);
        q0 = req0[d];
        q1 = req1[d];
        m_gw[d] = -1;
        if (m_left[d] == 0 && !rst && (q0 || q1))
            m_gw[d] = (q0 && q1) ? (m_last[d] ? 0 : 1) : (q0 ? 0 : 1);
        obs_g0[d] = grant0[d];
        obs_d1[d] = done1[d];
        chk({p, "grant0"}, 8'(grant0[d]), 8'(m_gw[d] == 0));
        chk({p, "grant1"}, 8'(grant1[d]), 8'(m_gw[d] == 1));
        chk({p, "done0"}, 8'(done0[d]), 8'(m_left[d] == 1 && m_who[d] == 0));
        chk({p, "done1"}, 8'(done1[d]), 8'(m_left[d] == 1 && m_who[d] == 1));
        chk({p, "busy"}, 8'(busy[d]), 8'(m_left[d] != 0));
        chk({p, "result0"}, result0[d], m_res[d][0]);
        chk({p, "result1"}, result1[d], m_res[d][1]);
        chk({p, "alu_select"}, 8'(alu_sel[d]), 8'(m_sel[d]));
        chk({p, "alu_data1"}, alu_d1[d], m_a[d]);
        chk({p, "alu_data2"}, alu_d2[d], m_b[d]);
    endtask

    task automatic model_edge(input int d);
        if (rst) begin
            m_left[d] = 0; m_last[d] = 1'b1; m_sel[d] = 3'b000; m_a[d] = 8'h00; m_b[d] = 8'h00;
            m_res[d][0] = 8'h00; m_res[d][1] = 8'h00;
        end else if (m_left[d] > 0) begin
            if (m_left[d] == 2) m_res[d][m_who[d]] = alu_ref(m_sel[d], m_a[d], m_b[d]);
            m_left[d]--;
        end else if (m_gw[d] >= 0) begin
            m_left[d] = waits[d] + 1;
            m_who[d]  = m_gw[d];
            m_last[d] = (m_gw[d] == 1);
            m_sel[d]  = (m_gw[d] == 1) ? sel1[d] : sel0[d];
            m_a[d]    = (m_gw[d] == 1) ? opa1[d] : opa0[d];
            m_b[d]    = (m_gw[d] == 1) ? opb1[d] : opb0[d];
        end
    endtask

    // Requesters: drop REQ after a grant; in random mode raise, withdraw and scramble operands.
    task automatic agent(input int d);
        if (m_gw[d] == 0 && !keep) begin
            req0[d] = 1'b0;
            if (rnd) begin opa0[d] = 8'($urandom); opb0[d] = 8'($urandom); end
        end else if (rnd && !req0[d] && $urandom_range(0, 3) == 0) begin
            req0[d] = 1'b1; sel0[d] = 3'($urandom_range(0, 7));
            opa0[d] = 8'($urandom); opb0[d] = 8'($urandom);
        end else if (rnd && req0[d] && $urandom_range(0, 19) == 0) begin
            req0[d] = 1'b0;
        end
        if (m_gw[d] == 1 && !keep) begin
            req1[d] = 1'b0;
            if (rnd) begin opa1[d] = 8'($urandom); opb1[d] = 8'($urandom); end
        end else if (rnd && !req1[d] && $urandom_range(0, 3) == 0) begin
            req1[d] = 1'b1; sel1[d] = 3'($urandom_range(0, 7));
            opa1[d] = 8'($urandom); opb1[d] = 8'($urandom);
        end else if (rnd && req1[d] && $urandom_range(0, 19) == 0) begin
            req1[d] = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) agent(d);
    endtask

    task automatic set_req(input int d, input int w, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        if (w == 0) begin req0[d] = 1'b1; sel0[d] = s; opa0[d] = a; opb0[d] = b; end
        else        begin req1[d] = 1'b1; sel1[d] = s; opa1[d] = a; opb1[d] = b; end
    endtask

    task automatic wait_grant(input int d, input int w);
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (m_gw[d] == w) return;
        end
        chk("grant timeout", 8'd0, 8'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int lat;
        int g0cnt;
        rst = 1'b1;
        req0 = '0; req1 = '0; sel0 = '0; sel1 = '0;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        for (int d = 0; d < 2; d++) begin
            m_left[d] = 0; m_who[d] = 0; m_gw[d] = -1; m_last[d] = 1'b1;
            m_res[d][0] = 8'h00; m_res[d][1] = 8'h00;
            m_sel[d] = 3'b000; m_a[d] = 8'h00; m_b[d] = 8'h00;
        end
        @(posedge clk); #1;
        run(2);
        rst = 1'b0;
        run(1);

        // Single ADD 3+1 on the WAIT=1 instance.
        set_req(0, 0, 3'b001, 8'h03, 8'h01);
        run(5);
        chk("add result0", result0[0], 8'h04);
        chk("add result1 untouched", result1[0], 8'h00);

        // Both requesters held: grants alternate, AND and OR results.
        keep = 1'b1;
        set_req(0, 0, 3'b010, 8'hD5, 8'hEA);
        set_req(0, 1, 3'b011, 8'h01, 8'h02);
        run(13);
        keep = 1'b0;
        run(8);
        chk("and result0", result0[0], 8'hC0);
        chk("or result1", result1[0], 8'h03);

        // ADD wrap and undefined opcode forwarding DATA2.
        set_req(0, 0, 3'b001, 8'hFF, 8'h02);
        run(5);
        chk("add wrap", result0[0], 8'h01);
        set_req(0, 1, 3'b111, 8'h33, 8'h5A);
        run(5);
        chk("sel 111 forward", result1[0], 8'h5A);

        // WAIT=4 instance: latency and operand change after grant.
        set_req(1, 1, 3'b000, 8'h11, 8'h7E);
        wait_grant(1, 1);
        opa1[1] = 8'hFF;
        opb1[1] = 8'h00;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (obs_d1[1]) begin lat = k; break; end
        end
        chk("w4 done latency", 8'(lat), 8'd5);
        chk("w4 forward result", result1[1], 8'h7E);
        run(2);

        // Reset during EXEC aborts, then a tie goes to requester 0.
        set_req(1, 0, 3'b001, 8'h10, 8'h20);
        wait_grant(1, 0);
        run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("reset busy", 8'(busy[1]), 8'd0);
        chk("reset result1", result1[1], 8'h00);
        chk("reset result0", result0[1], 8'h00);
        run(2);
        set_req(1, 0, 3'b010, 8'hF0, 8'h3C);
        set_req(1, 1, 3'b011, 8'h0F, 8'h30);
        run(1);
        chk("tie after reset grant0", 8'(obs_g0[1]), 8'd1);
        run(14);
        chk("tie and result0", result0[1], 8'h30);
        chk("tie or result1", result1[1], 8'h3F);

        // REQ0 pulsed while busy must never be granted.
        set_req(1, 1, 3'b001, 8'h05, 8'h06);
        wait_grant(1, 1);
        set_req(1, 0, 3'b001, 8'h99, 8'h99);
        run(1);
        req0[1] = 1'b0;
        g0cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (obs_g0[1]) g0cnt++;
        end
        chk("withdrawn req0 no grant", 8'(g0cnt), 8'd0);
        chk("withdrawn req0 result0", result0[1], 8'h30);

        // Random traffic on both instances.
        rnd = 1'b1;
        run(800);
        rnd = 1'b0;
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
